// File: rtl/count_job_dispatcher.sv
// Count-job dispatcher: buffers {word, sel} jobs in a small FIFO, issues them one at a
// time to a serial bit counter, and collects each tagged result or aborts on timeout.
module count_job_dispatcher #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int TMO   = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [W-1:0] job_data,
    input  logic [1:0]   job_sel,
    output logic [W-1:0] a_in,
    output logic [1:0]   sel,
    output logic         start,
    input  logic         done,
    input  logic [W-1:0] cntout,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    output logic [1:0]   res_sel,
    output logic         sel_err,
    output logic         tmo_err,
    output logic         busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TMO);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [W+1:0]  mem_q [DEPTH];
    logic [TW-1:0] timer_q, timer_d;
    logic [W-1:0]  a_in_q, a_in_d;
    logic [1:0]    sel_q, sel_d;
    logic [W-1:0]  res_data_q, res_data_d;
    logic [1:0]    res_sel_q, res_sel_d;
    logic          res_valid_q, res_valid_d;
    logic          sel_err_q, sel_err_d;
    logic          tmo_err_q, tmo_err_d;

    logic fifo_empty, fifo_full, sel_legal, accept, push, pop;

    // Equal pointers mean empty; equal index with opposite wrap bit means full.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign sel_legal = (job_sel == 2'b10) || (job_sel == 2'b01);
    assign accept    = job_valid && !fifo_full;
    assign push      = accept && sel_legal;
    assign pop       = (state_q == S_IDLE) && !fifo_empty;

    // NOTE: every _d signal gets its default before the case so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        timer_d     = timer_q;
        a_in_d      = a_in_q;
        sel_d       = sel_q;
        res_data_d  = res_data_q;
        res_sel_d   = res_sel_q;
        res_valid_d = 1'b0;
        tmo_err_d   = 1'b0;
        sel_err_d   = accept && !sel_legal;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    rd_ptr_d        = rd_ptr_q + 1'b1;
                    {a_in_d, sel_d} = mem_q[rd_ptr_q[AW-1:0]];
                    state_d         = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (done) begin
                    res_data_d  = cntout;
                    res_sel_d   = sel_q;
                    res_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (timer_q == TW'(TMO - 1)) begin
                    tmo_err_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            timer_q     <= '0;
            a_in_q      <= '0;
            sel_q       <= '0;
            res_data_q  <= '0;
            res_sel_q   <= '0;
            res_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            timer_q     <= timer_d;
            a_in_q      <= a_in_d;
            sel_q       <= sel_d;
            res_data_q  <= res_data_d;
            res_sel_q   <= res_sel_d;
            res_valid_q <= res_valid_d;
            sel_err_q   <= sel_err_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    // NOTE: job storage is not reset; an entry is only read after a push has written it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {job_data, job_sel};
        end
    end

    assign job_ready = !fifo_full;
    assign start     = (state_q == S_ISSUE);
    assign busy      = (state_q != S_IDLE) || !fifo_empty;
    assign a_in      = a_in_q;
    assign sel       = sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_sel   = res_sel_q;
    assign sel_err   = sel_err_q;
    assign tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_count_job_dispatcher.sv
// Self-checking bench: emulates the bit counter, runs directed scenarios, and scores every
// cycle against a timestamp-based model of the job queue and dispatcher.
module tb_count_job_dispatcher;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         job_valid = 1'b0;
    logic [W-1:0] job_data = '0;
    logic [1:0]   job_sel = '0;
    logic         done = 1'b0;
    logic [W-1:0] cntout = '0;
    logic         job_ready, start, res_valid, sel_err, tmo_err, busy;
    logic [W-1:0] a_in, res_data;
    logic [1:0]   sel, res_sel;

    int total = 0;
    int bad   = 0;

    count_job_dispatcher #(.W(W), .DEPTH(DEPTH), .TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_data(job_data), .job_sel(job_sel),
        .a_in(a_in), .sel(sel), .start(start), .done(done), .cntout(cntout),
        .res_valid(res_valid), .res_data(res_data), .res_sel(res_sel),
        .sel_err(sel_err), .tmo_err(tmo_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Counter emulator: next_lat = cycles from start to done (0 = never), or random latency.
    int           next_lat = 0;
    bit           rand_lat = 0;
    bit           stray_en = 0;
    int           remaining = 0;
    logic [W-1:0] emu_word = '0;
    logic [1:0]   emu_sel = '0;

    always @(posedge clk) begin
        #1;
        done   = 1'b0;
        cntout = '0;
        if (start === 1'b1) begin
            emu_word = a_in;
            emu_sel  = sel;
            if (rand_lat)
                remaining = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO + 2);
            else
                remaining = next_lat;
            if (stray_en && $urandom_range(0, 3) == 0) begin
                done   = 1'b1;
                cntout = 8'($urandom);
            end
        end else if (remaining > 0) begin
            remaining--;
            if (remaining == 0) begin
                done   = 1'b1;
                cntout = (emu_sel == 2'b10) ? 8'($countones(emu_word))
                                            : 8'(W - $countones(emu_word));
            end
        end else if (stray_en && $urandom_range(0, 7) == 0) begin
            done   = 1'b1;
            cntout = 8'($urandom);
        end
    end

    // Reference model: queue of accepted jobs plus the cycle numbers of expected events.
    typedef struct packed {
        logic [W-1:0] d;
        logic [1:0]   s;
    } job_t;

    job_t         m_fifo[$];
    job_t         mj;
    bit           m_armed = 0;
    bit           m_idle = 1;
    bit           m_ready;
    longint       cyc = 0;
    longint       m_start = -1, m_deadline = -1, m_res_cyc = -1, m_tmo_cyc = -1, m_serr_cyc = -1;
    logic [W-1:0] m_a = '0, m_res = '0;
    logic [1:0]   m_s = '0, m_rsel = '0;
    logic         e_start, e_busy;

    always @(negedge clk) begin
        cyc++;
        if (m_armed) begin
            e_start = !m_idle && (cyc == m_start);
            e_busy  = !m_idle || (m_fifo.size() > 0);
            total += 8;
            if (start !== e_start) begin
                bad++; $display("FAIL model_start cyc=%0d got=%b want=%b", cyc, start, e_start);
            end
            if ({a_in, sel} !== {m_a, m_s}) begin
                bad++; $display("FAIL model_issue cyc=%0d got=%h/%b want=%h/%b", cyc, a_in, sel, m_a, m_s);
            end
            if (res_valid !== (cyc == m_res_cyc)) begin
                bad++; $display("FAIL model_res_valid cyc=%0d got=%b want=%b", cyc, res_valid, cyc == m_res_cyc);
            end
            if ({res_data, res_sel} !== {m_res, m_rsel}) begin
                bad++; $display("FAIL model_result cyc=%0d got=%h/%b want=%h/%b", cyc, res_data, res_sel, m_res, m_rsel);
            end
            if (tmo_err !== (cyc == m_tmo_cyc)) begin
                bad++; $display("FAIL model_tmo_err cyc=%0d got=%b want=%b", cyc, tmo_err, cyc == m_tmo_cyc);
            end
            if (sel_err !== (cyc == m_serr_cyc)) begin
                bad++; $display("FAIL model_sel_err cyc=%0d got=%b want=%b", cyc, sel_err, cyc == m_serr_cyc);
            end
            if (job_ready !== (m_fifo.size() < DEPTH)) begin
                bad++; $display("FAIL model_job_ready cyc=%0d got=%b want=%b", cyc, job_ready, m_fifo.size() < DEPTH);
            end
            if (busy !== e_busy) begin
                bad++; $display("FAIL model_busy cyc=%0d got=%b want=%b", cyc, busy, e_busy);
            end
        end

        if (rst === 1'b1) begin
            m_fifo.delete();
            m_idle  = 1; m_a = '0; m_s = '0; m_res = '0; m_rsel = '0;
            m_start = -1; m_deadline = -1; m_res_cyc = -1; m_tmo_cyc = -1; m_serr_cyc = -1;
            m_armed = 1;
        end else if (m_armed) begin
            m_ready = (m_fifo.size() < DEPTH);
            if (!m_idle && cyc > m_start && cyc <= m_deadline && done === 1'b1) begin
                m_res = cntout; m_rsel = m_s; m_res_cyc = cyc + 1; m_idle = 1;
            end else if (!m_idle && cyc == m_deadline) begin
                m_tmo_cyc = cyc + 1; m_idle = 1;
            end else if (m_idle && m_fifo.size() > 0) begin
                mj = m_fifo.pop_front();
                m_a = mj.d; m_s = mj.s;
                m_start = cyc + 1; m_deadline = cyc + 1 + TMO; m_idle = 0;
            end
            if (job_valid === 1'b1 && m_ready) begin
                if (job_sel == 2'b10 || job_sel == 2'b01) m_fifo.push_back('{d: job_data, s: job_sel});
                else m_serr_cyc = cyc + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds a job on the input until it is accepted; returns one cycle after the handshake.
    task automatic offer(input logic [W-1:0] d, input logic [1:0] s);
        bit acc = 0;
        job_valid = 1'b1; job_data = d; job_sel = s;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clk);
            acc = (job_ready === 1'b1);
            tick();
        end
        job_valid = 1'b0;
        total++;
        if (!acc) begin bad++; $display("FAIL offer_accept got=never_ready want=accepted"); end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin tick(); n++; end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL wait_idle got busy=%b want=0", busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        total += 3;
        if ({start, res_valid, sel_err, tmo_err, busy} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=00000", {start, res_valid, sel_err, tmo_err, busy});
        end
        if ({a_in, sel, res_data, res_sel} !== '0) begin
            bad++; $display("FAIL reset_data got=%h want=0", {a_in, sel, res_data, res_sel});
        end
        if (job_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", job_ready); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int n = 0;
        bit seen = 0;
        next_lat = 8;
        offer(8'b0000_1011, 2'b10);
        @(negedge clk);
        total++;
        if (start !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL single_pop got start=%b busy=%b want 0/1", start, busy);
        end
        @(negedge clk);
        total++;
        if (start !== 1'b1 || a_in !== 8'h0B || sel !== 2'b10) begin
            bad++; $display("FAIL single_start got %b %h %b want 1 0b 10", start, a_in, sel);
        end
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            seen = (res_valid === 1'b1);
            total++;
            if (a_in !== 8'h0B || sel !== 2'b10) begin
                bad++; $display("FAIL single_hold got %h/%b want 0b/10", a_in, sel);
            end
        end
        total += 2;
        if (n != 9) begin bad++; $display("FAIL single_latency got=%0d want=9", n); end
        if (res_data !== 8'd3 || res_sel !== 2'b10) begin
            bad++; $display("FAIL single_result got %h/%b want 03/10", res_data, res_sel);
        end
        @(negedge clk);
        total++;
        if (res_valid !== 1'b0) begin bad++; $display("FAIL single_pulse got=%b want=0", res_valid); end
        tick();
        next_lat = 0;
    endtask

    task automatic test_sel_err();
        int n = 0;
        wait_idle();
        next_lat = 5;
        job_valid = 1'b1; job_data = 8'hA5; job_sel = 2'b00;
        @(negedge clk);
        total++;
        if (job_ready !== 1'b1) begin bad++; $display("FAIL selerr_ready got=%b want=1", job_ready); end
        tick();
        job_data = 8'b0000_0100; job_sel = 2'b01;
        @(negedge clk);
        total++;
        if (sel_err !== 1'b1 || start !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL selerr_pulse got %b %b %b want 1 0 0", sel_err, start, busy);
        end
        tick();
        job_valid = 1'b0;
        @(negedge clk);
        total++;
        if (sel_err !== 1'b0 || start !== 1'b0) begin
            bad++; $display("FAIL selerr_single got %b/%b want 0/0", sel_err, start);
        end
        @(negedge clk);
        total++;
        if (start !== 1'b1 || sel !== 2'b01 || a_in !== 8'h04) begin
            bad++; $display("FAIL selerr_next_start got %b %b %h want 1 01 04", start, sel, a_in);
        end
        do begin @(negedge clk); n++; end while (res_valid !== 1'b1 && n < 60);
        total++;
        if (res_valid !== 1'b1 || res_data !== 8'd7 || res_sel !== 2'b01) begin
            bad++; $display("FAIL selerr_result got %b %h %b want 1 07 01", res_valid, res_data, res_sel);
        end
        tick();
        next_lat = 0;
    endtask

    task automatic test_back_to_back();
        int stall = 0;
        wait_idle();
        next_lat = 0;
        for (int i = 0; i <= DEPTH; i++) offer(8'h10 + 8'(i), 2'b10);
        job_valid = 1'b1; job_data = 8'h55; job_sel = 2'b01;
        @(negedge clk);
        total++;
        if (job_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b want=0", job_ready); end
        while (job_ready !== 1'b1 && stall < 200) begin
            stall++;
            tick();
            @(negedge clk);
        end
        tick();
        job_valid = 1'b0;
        total++;
        if (stall != TMO + 3 - DEPTH) begin
            bad++; $display("FAIL b2b_stall got=%0d want=%0d", stall, TMO + 3 - DEPTH);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        do begin @(negedge clk); n++; end while (tmo_err !== 1'b1 && n < 100);
        total++;
        if (tmo_err !== 1'b1 || res_valid !== 1'b0) begin
            bad++; $display("FAIL tmo_seen got tmo=%b res=%b want 1/0", tmo_err, res_valid);
        end
        @(negedge clk);
        total++;
        if (start !== 1'b1 || tmo_err !== 1'b0 || a_in !== 8'h12) begin
            bad++; $display("FAIL tmo_next_issue got %b %b %h want 1 0 12", start, tmo_err, a_in);
        end
        n = 0;
        do begin @(negedge clk); n++; end while (tmo_err !== 1'b1 && n < 100);
        total++;
        if (n != TMO + 1) begin bad++; $display("FAIL tmo_latency got=%0d want=%0d", n, TMO + 1); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        total++;
        if (start !== 1'b1 || a_in !== 8'h13) begin
            bad++; $display("FAIL rstmid_issue got %b %h want 1 13", start, a_in);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({start, res_valid, sel_err, tmo_err, busy, a_in, sel, job_ready} !== {5'b0, 8'h00, 2'b00, 1'b1}) begin
            bad++; $display("FAIL rstmid_outputs got %b %h %b %b want 00000 00 00 1",
                            {start, res_valid, sel_err, tmo_err, busy}, a_in, sel, job_ready);
        end
        repeat (40) begin
            @(negedge clk);
            total++;
            if ({res_valid, start, tmo_err, busy} !== 4'b0) begin
                bad++; $display("FAIL rstmid_quiet got=%b want=0000", {res_valid, start, tmo_err, busy});
            end
        end
        tick();
    endtask

    task automatic test_done_vs_timeout();
        int n = 0;
        wait_idle();
        next_lat = TMO;
        offer(8'hF0, 2'b10);
        do begin @(negedge clk); n++; end while (start !== 1'b1 && n < 10);
        n = 0;
        do begin @(negedge clk); n++; end while (res_valid !== 1'b1 && tmo_err !== 1'b1 && n < 100);
        total += 2;
        if (res_valid !== 1'b1 || tmo_err !== 1'b0 || res_data !== 8'd4) begin
            bad++; $display("FAIL race_done_wins got res=%b tmo=%b data=%h want 1 0 04", res_valid, tmo_err, res_data);
        end
        if (n != TMO + 1) begin bad++; $display("FAIL race_latency got=%0d want=%0d", n, TMO + 1); end
        @(negedge clk);
        total++;
        if (tmo_err !== 1'b0) begin bad++; $display("FAIL race_no_late_tmo got=%b want=0", tmo_err); end
        tick();
        next_lat = 0;
    endtask

    task automatic test_random();
        logic [1:0] s;
        int r;
        wait_idle();
        rand_lat = 1;
        stray_en = 1;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            s = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b10 : 2'b01;
            offer(8'($urandom), s);
            repeat ($urandom_range(0, 5)) tick();
            if (i == 150) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        rand_lat = 0;
        stray_en = 0;
        wait_idle();
        @(negedge clk);
        total++;
        if (job_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL random_drained got ready=%b busy=%b want 1/0", job_ready, busy);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_sel_err();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_done_vs_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
